// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of one shared combinational ALU.
// The granted lane's operands go to the ALU; the result returns through a one-deep response register.
module alu_issue_arbiter #(
   parameter int         DATA_WIDTH = 64,
   parameter int         NUM_REQ    = 4,
   parameter int         ID_WIDTH   = $clog2(NUM_REQ),
   parameter logic [4:0] MAX_FUNC   = 5'b01001
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ*5-1:0]          req_func,
   output logic [DATA_WIDTH-1:0]         alu_a,
   output logic [DATA_WIDTH-1:0]         alu_b,
   output logic [4:0]                    alu_func,
   input  logic [DATA_WIDTH-1:0]         alu_result,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic                          rsp_err
);

   localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] grant_idx;
   logic [ID_WIDTH:0]   cand;
   logic                grant_found;
   logic                grant_ok;
   logic                slot_free;
   logic                func_err;

   assign slot_free = !rsp_valid || rsp_ready;

   // First valid lane at or after rr_ptr, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_WIDTH-1:0];
         end
      end
   end

   // Reset gates the grant so nothing is accepted while rst_n is low.
   assign grant_ok  = grant_found && slot_free && rst_n;
   assign req_ready = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;

   // Idle ALU inputs are held at zero to avoid toggling the shared datapath.
   assign alu_a    = grant_ok ? req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign alu_b    = grant_ok ? req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign alu_func = grant_ok ? req_func[int'(grant_idx)*5 +: 5] : '0;
   assign func_err = alu_func > MAX_FUNC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         rr_ptr    <= '0;
      end else if (grant_ok) begin
         rsp_valid <= 1'b1;
         rsp_data  <= func_err ? '0 : alu_result;
         rsp_id    <= grant_idx;
         rsp_err   <= func_err;
         rr_ptr    <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a small reference ALU and a response scoreboard.
module tb_alu_issue_arbiter;

   localparam int DW = 64;
   localparam int NR = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
      logic          err;
   } rsp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic [NR*5-1:0] req_func;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [4:0]      alu_func;
   logic [DW-1:0]   alu_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic [IW-1:0]   rsp_id;
   logic            rsp_err;

   int   tests = 0;
   int   fails = 0;
   rsp_t sb_q[$];

   alu_issue_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_func(req_func),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Reference ALU: 0 ADD, 1 AND, 2 SUB, 3 OR, 4 XOR; anything else returns junk.
   always_comb begin
      case (alu_func)
         5'd0:    alu_result = alu_a + alu_b;
         5'd1:    alu_result = alu_a & alu_b;
         5'd2:    alu_result = alu_a - alu_b;
         5'd3:    alu_result = alu_a | alu_b;
         5'd4:    alu_result = alu_a ^ alu_b;
         default: alu_result = 64'hDEAD_BEEF_0BAD_F00D;
      endcase
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] f);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req_func[i*5 +: 5] = f;
   endtask

   task automatic step();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Check the grant at the sampling point; on a grant, queue the hand-computed response.
   task automatic expect_grant(input string name, input logic [NR-1:0] exp_ready,
                               input logic [DW-1:0] data, input logic [IW-1:0] id, input logic err);
      rsp_t e;
      @(negedge clk);
      check(name, DW'(req_ready), DW'(exp_ready));
      if (exp_ready != '0) begin
         e.data = data;
         e.id   = id;
         e.err  = err;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed response handshake is compared against the scoreboard front.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", rsp_id, rsp_data);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_id", DW'(rsp_id), DW'(e.id));
            check("rsp_err", DW'(rsp_err), DW'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_func  = '0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(negedge clk);
      check("ready_in_reset", DW'(req_ready), 0);
      @(posedge clk); #1;
      check("reset_valid", DW'(rsp_valid), 0);
      check("reset_data", rsp_data, 0);
      check("reset_id", DW'(rsp_id), 0);
      check("reset_err", DW'(rsp_err), 0);
      req_valid = '0;
      rst_n     = 1'b1;

      // Single request on lane 2, held in the response register.
      set_lane(2, 64'd5, 64'd3, 5'b00010);
      req_valid = 4'b0100;
      @(negedge clk);
      check("single_ready", DW'(req_ready), 64'h4);
      check("single_alu_a", alu_a, 64'd5);
      check("single_alu_func", DW'(alu_func), 64'd2);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("single_rsp_valid", DW'(rsp_valid), 1);
      check("single_rsp_data", rsp_data, 64'd2);
      check("single_rsp_id", DW'(rsp_id), 64'd2);
      check("single_rsp_err", DW'(rsp_err), 0);
      @(posedge clk); #1;

      // Reset with a pending response and rr_ptr at 3.
      for (int i = 0; i < NR; i++) set_lane(i, DW'(10*(i+1)), DW'(i+1), 5'd0);
      req_valid = 4'b1111;
      rst_n     = 1'b0;
      @(negedge clk);
      check("midreset_ready", DW'(req_ready), 0);
      @(posedge clk); #1;
      check("midreset_valid", DW'(rsp_valid), 0);
      sb_q.delete();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // Contention: grants 0,1,2,3,0.
      expect_grant("cont_g0", 4'b0001, 64'd11, 2'd0, 1'b0);
      expect_grant("cont_g1", 4'b0010, 64'd22, 2'd1, 1'b0);
      expect_grant("cont_g2", 4'b0100, 64'd33, 2'd2, 1'b0);
      expect_grant("cont_g3", 4'b1000, 64'd44, 2'd3, 1'b0);
      expect_grant("cont_g4", 4'b0001, 64'd11, 2'd0, 1'b0);
      req_valid = '0;
      step();

      // Lane 3 alone moves rr_ptr back to 0.
      set_lane(3, 64'd1, 64'd1, 5'd4);
      req_valid = 4'b1000;
      expect_grant("lane3_grant", 4'b1000, 64'd0, 2'd3, 1'b0);
      req_valid = '0;
      step();

      // Backpressure with lanes 0 and 1 pending.
      set_lane(0, 64'd100, 64'd7, 5'd1);
      set_lane(1, 64'd9, 64'd6, 5'd3);
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      expect_grant("bp_first", 4'b0001, 64'd4, 2'd0, 1'b0);
      req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_ready_blocked", DW'(req_ready), 0);
         check("bp_hold_valid", DW'(rsp_valid), 1);
         check("bp_hold_data", rsp_data, 64'd4);
         check("bp_hold_id", DW'(rsp_id), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      expect_grant("bp_release", 4'b0010, 64'd15, 2'd1, 1'b0);
      req_valid = '0;
      step();

      // Illegal function code, then a legal SUB that wraps.
      set_lane(1, 64'd1, 64'd2, 5'b11111);
      req_valid = 4'b0010;
      expect_grant("illegal_grant", 4'b0010, 64'd0, 2'd1, 1'b1);
      set_lane(1, 64'd3, 64'd5, 5'b00010);
      expect_grant("sub_grant", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFE, 2'd1, 1'b0);
      req_valid = '0;

      // Idle: ALU inputs quiet, pointer unchanged (still 2).
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("idle_alu_a", alu_a, 0);
         check("idle_alu_b", alu_b, 0);
         check("idle_alu_func", DW'(alu_func), 0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < NR; i++) set_lane(i, DW'(10*(i+1)), DW'(i+1), 5'd0);
      req_valid = 4'b1111;
      expect_grant("idle_ptr_kept", 4'b0100, 64'd33, 2'd2, 1'b0);
      req_valid = '0;

      for (int c = 0; c < 10 && sb_q.size() != 0; c++) step();
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending responses expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares one combinational integer ALU between `NUM_REQ` requesters (decode lanes, address-gen, branch unit).
- Selects one valid request per cycle by round-robin and drives its operands and function code onto the ALU.
- Captures the ALU result in a one-deep output register and returns it with the requester's index over a valid/ready response channel.
- Sits between the issue logic and the shared `alu` instance.

## Interface
- `DATA_WIDTH`, 64, operand/result width; must match the attached ALU.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, width of the requester index.
- `MAX_FUNC`, 5'b01001, highest legal ALU function code.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant; at most one bit high.
- `req_a`  in  `NUM_REQ*DATA_WIDTH`  operand A; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`  in  `NUM_REQ*DATA_WIDTH`  operand B, same packing as `req_a`.
- `req_func`  in  `NUM_REQ*5`  function code; lane i at `[i*5 +: 5]`.
- `alu_a`, `alu_b`  out  `DATA_WIDTH`  operands to the ALU.
- `alu_func`  out  5  function code to the ALU.
- `alu_result`  in  `DATA_WIDTH`  combinational ALU result.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  `DATA_WIDTH`  registered result.
- `rsp_id`  out  `ID_WIDTH`  index of the originating requester.
- `rsp_err`  out  1  request carried a function code > `MAX_FUNC`.

## Operation
- **Slot free:** `slot_free = !rsp_valid || rsp_ready`.
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - `req_ready[g]=1` only when `slot_free`; all `req_ready` are 0 otherwise.
- **Handshake:** a request is accepted when `req_valid[g] && req_ready[g]`.
  - Requesters must hold valid and payload stable until accepted.
  - `req_ready` may depend combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **ALU drive:**
  - When a grant exists, `alu_a/alu_b/alu_func` carry the granted lane's payload.
  - Otherwise they are all-zero, so no toggling while idle.
- **On accept:**
  - `rsp_data <= alu_result` and `rsp_id <= g`.
  - `rsp_err <= (req_func[g] > MAX_FUNC)`; when set, `rsp_data <= 0` regardless of `alu_result`.
  - `rsp_valid <= 1` and `rr_ptr <= (g+1) mod NUM_REQ`.
- **Drain with no accept:** `rsp_valid && rsp_ready` with no new accept sets `rsp_valid <= 0`. `rsp_data/rsp_id/rsp_err` hold their last values.
- **Pointer:** `rr_ptr` changes only on accept.
- **Arithmetic:** widths and wrap are the ALU's, passed through unmodified. The block does no arithmetic of its own.
- **Reset (rst_n=0 at an edge):**
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `rsp_err=0`, `rr_ptr=0`.
  - While `rst_n=0`, `req_ready` is forced to 0, so nothing is accepted in the reset cycle.
  - An in-flight response is dropped.

## Timing
- Latency: accept at edge t gives `rsp_valid=1` with the result for cycles after edge t.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Back-to-back: accept and drain in the same cycle keep `rsp_valid=1` with the new data.
- Backpressure: `rsp_valid=1 && rsp_ready=0` holds the response stable and blocks all grants.
- Critical path: `req_valid` → arbiter → payload mux → ALU → `rsp_data` register; single cycle.

## Test plan
- **Single request:** after reset, lane 2 requests A=5, B=3, func 5'b00010.
  - `req_ready=4'b0100` that cycle.
  - Next cycle: `rsp_valid=1`, `rsp_data=2`, `rsp_id=2`, `rsp_err=0`.
- **Contention:** all 4 lanes hold valid with `rsp_ready=1`.
  - Grants go in order 0,1,2,3,0, one per cycle.
  - `rsp_id` follows the same order, one cycle later.
- **Backpressure:** `rsp_ready=0` for 3 cycles with lanes 0 and 1 valid.
  - Only lane 0 is accepted; `req_ready=0` while blocked.
  - `rsp_data/rsp_id` stay stable.
  - Raising `rsp_ready` accepts lane 1 in that same cycle.
- **Illegal func:** lane 1 sends func 5'b11111.
  - `rsp_err=1` and `rsp_data=0`.
  - A following legal SUB 3-5 unsigned gives `rsp_err=0`, `rsp_data=64'hFFFF_FFFF_FFFF_FFFE`.
- **Reset mid-flight:** `rsp_valid=1`, `rr_ptr=3`, then `rst_n=0` for one edge.
  - Next cycle: `rsp_valid=0` and `req_ready=0` during reset.
  - After release, all-valid grants lane 0 first.
- **Idle:** no `req_valid` → `alu_a/alu_b/alu_func` all zero and `rr_ptr` unchanged.
